// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   INST_W             : PC / instruction width carried in a queue entry
//   RESET_ADDR_DEFAULT : default first fetch address after reset
//   fe_entry_t         : fetch queue entry, {pc, inst}
package fetch_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] RESET_ADDR_DEFAULT = 32'hbfc00000;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fe_entry_t;

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO of fe_entry_t. Flush wins over push.
//   clk, reset : clock, synchronous active-high reset
//   push_i     : write wdata_i at the tail (ignored on flush)
//   pop_i      : drop the head (caller guarantees count_o != 0)
//   flush_i    : empty the queue and rewind both pointers
//   wdata_i    : entry to write
//   count_o    : occupancy, 0..DEPTH
//   head_o     : raw storage at the read pointer (caller masks when empty)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fe_entry_t        wdata_i,
  output logic [CNT_W-1:0] count_o,
  output fe_entry_t        head_o
);

  fe_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer/count next state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + PTR_W'(1);
      if (pop_i)  rptr_d = rptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an empty queue never exposes it.
  always_ff @(posedge clk) begin
    if (!reset && push_i && !flush_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: PC generator, synchronous SRAM request port and a
// DEPTH-entry fetch queue presenting {pc, inst} to decode under valid/ready.
//   clk, reset       : clock, synchronous active-high reset
//   inst_sram_en     : read request this cycle
//   inst_sram_addr   : read address (data returns one cycle later)
//   inst_sram_rdata  : read data for the previous cycle's request
//   br_valid         : redirect; flushes queue and in-flight fetch
//   br_target        : redirect address (word aligned)
//   fe_valid/fe_pc/fe_inst : queue head to decode (zeroed when not valid)
//   de_ready         : decode accepts the head
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(RESET_ADDR_DEFAULT),
  parameter int unsigned     DEPTH      = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            inst_sram_en,
  output logic [XLEN-1:0] inst_sram_addr,
  input  logic [XLEN-1:0] inst_sram_rdata,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  output logic            fe_valid,
  output logic [XLEN-1:0] fe_pc,
  output logic [XLEN-1:0] fe_inst,
  input  logic            de_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [XLEN-1:0]  pc_req_q, pc_req_d;
  logic [XLEN-1:0]  req_addr_q, req_addr_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count;
  logic [OCC_W-1:0] occupancy;
  logic             push;
  logic             pop;
  fe_entry_t        head;
  fe_entry_t        wdata;

  assign fe_valid = (count != '0);
  assign pop      = fe_valid & de_ready;
  assign push     = inflight_q & ~br_valid;

  // Slots already committed after this cycle's pop; issuing only below DEPTH
  // guarantees every in-flight response has a free entry.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);

  assign inst_sram_en   = ~reset & (br_valid | (occupancy < OCC_W'(DEPTH)));
  assign inst_sram_addr = reset    ? RESET_ADDR :
                          br_valid ? br_target  : pc_req_q;

  // PC generator and in-flight tracking.
  always_comb begin
    pc_req_d   = pc_req_q;
    req_addr_d = req_addr_q;
    inflight_d = inst_sram_en;
    if (inst_sram_en) begin
      pc_req_d   = inst_sram_addr + XLEN'(4);
      req_addr_d = inst_sram_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_req_q   <= RESET_ADDR;
      req_addr_q <= RESET_ADDR;
      inflight_q <= 1'b0;
    end else begin
      pc_req_q   <= pc_req_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
    end
  end

  assign wdata.pc   = INST_W'(req_addr_q);
  assign wdata.inst = INST_W'(inst_sram_rdata);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (br_valid),
    .wdata_i (wdata),
    .count_o (count),
    .head_o  (head)
  );

  assign fe_pc   = fe_valid ? XLEN'(head.pc)   : '0;
  assign fe_inst = fe_valid ? XLEN'(head.inst) : '0;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: SRAM model returns addr ^ KEY one cycle
// after a request; a scoreboard of expected decode PCs is loaded at reset
// release and on each redirect, and popped on every fe_valid & de_ready.
module tb_fetch_queue_stage;

  localparam logic [31:0] RST_A = 32'hbfc00000;
  localparam logic [31:0] KEY   = 32'h5a5aa5a5;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = '0;
  logic        br_valid;
  logic [31:0] br_target;
  logic        fe_valid;
  logic [31:0] fe_pc;
  logic [31:0] fe_inst;
  logic        de_ready;

  int          n_cmp = 0;
  int          n_err = 0;
  int          pops  = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  fetch_queue_stage #(
    .XLEN       (32),
    .RESET_ADDR (RST_A),
    .DEPTH      (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .br_valid        (br_valid),
    .br_target       (br_target),
    .fe_valid        (fe_valid),
    .fe_pc           (fe_pc),
    .fe_inst         (fe_inst),
    .de_ready        (de_ready)
  );

  // Synchronous instruction SRAM model.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ KEY;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] base);
    exp_q.delete();
    for (int k = 0; k < 48; k++) exp_q.push_back(base + 32'(4 * k));
  endtask

  // One cycle: drive inputs at the falling edge, then check the handshake.
  task automatic tick(input logic rdy, input logic brv, input logic [31:0] tgt,
                      input logic rst);
    logic [31:0] e;
    @(negedge clk);
    de_ready  = rdy;
    br_valid  = brv;
    br_target = tgt;
    reset     = rst;
    #1;
    if (rst) begin
      load(RST_A);
    end else begin
      if (fe_valid && de_ready) begin
        pops++;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL sb_underflow: observed pc %h with empty scoreboard", fe_pc);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_pc", fe_pc, e);
          chk("sb_inst", fe_inst, e ^ KEY);
        end
      end else if (!fe_valid) begin
        chk("idle_pc", fe_pc, 32'h0);
        chk("idle_inst", fe_inst, 32'h0);
      end
      if (brv) load(tgt);
    end
  endtask

  initial begin
    reset     = 1'b1;
    de_ready  = 1'b0;
    br_valid  = 1'b0;
    br_target = '0;

    // Reset held.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      chk("rst_en", 32'(inst_sram_en), 32'd0);
      chk("rst_addr", inst_sram_addr, RST_A);
      chk("rst_valid", 32'(fe_valid), 32'd0);
    end

    // Sequential fetch, back-pressure in cycles 4..9, then resume.
    pops = 0;
    for (int c = 0; c < 26; c++) begin
      tick((c < 4 || c > 9), 1'b0, 32'h0, 1'b0);
      if (c == 0) begin
        chk("c0_en", 32'(inst_sram_en), 32'd1);
        chk("c0_addr", inst_sram_addr, RST_A);
      end
      chk("seq_valid", 32'(fe_valid), (c < 2) ? 32'd0 : 32'd1);
      if (c == 2) chk("c2_pc", fe_pc, RST_A);
      if (c >= 4 && c <= 9) chk("bp_en", 32'(inst_sram_en), 32'd0);
      if (c == 10) chk("resume_en", 32'(inst_sram_en), 32'd1);
    end
    chk("phaseA_pops", 32'(pops), 32'd18);

    // Fill queue, then redirect with head consumed the same cycle.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 32'h80001000, 1'b0);
    chk("br_en", 32'(inst_sram_en), 32'd1);
    chk("br_addr", inst_sram_addr, 32'h80001000);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("br_r1_valid", 32'(fe_valid), 32'd0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("br_r2_valid", 32'(fe_valid), 32'd1);
    chk("br_r2_pc", fe_pc, 32'h80001000);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("br_r3_pc", fe_pc, 32'h80001004);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);

    // Back-to-back redirects: only the second target stream may appear.
    tick(1'b1, 1'b1, 32'h00400000, 1'b0);
    tick(1'b1, 1'b1, 32'h00500000, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("bb_r1_valid", 32'(fe_valid), 32'd0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("bb_r2_pc", fe_pc, 32'h00500000);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);

    // PC wrap-around.
    tick(1'b1, 1'b1, 32'hfffffff8, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_pc0", fe_pc, 32'hfffffff8);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_pc1", fe_pc, 32'hfffffffc);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_pc2", fe_pc, 32'h00000000);
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);

    // One-cycle reset mid-stream with a concurrent redirect.
    tick(1'b1, 1'b1, 32'h12345678, 1'b1);
    chk("mrst_en", 32'(inst_sram_en), 32'd0);
    chk("mrst_addr", inst_sram_addr, RST_A);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mrst_c0_valid", 32'(fe_valid), 32'd0);
    chk("mrst_c0_addr", inst_sram_addr, RST_A);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mrst_c1_valid", 32'(fe_valid), 32'd0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mrst_c2_pc", fe_pc, RST_A);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
